// File: rtl/sseg_scan_decoder_if.sv
// Multiplexed seven-segment display bus plus the decoded frame outputs.
// The master drives the scan lines; the slave (decoder) returns rebuilt digits.
interface sseg_scan_decoder_if #(
  parameter int unsigned DIGITS = 4
);
  logic [DIGITS-1:0]   an;
  logic [7:0]          seg;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank_mask;
  logic                frame_valid;
  logic                code_err;

  modport master (
    output an,
    output seg,
    input  value,
    input  blank_mask,
    input  frame_valid,
    input  code_err
  );

  modport slave (
    input  an,
    input  seg,
    output value,
    output blank_mask,
    output frame_valid,
    output code_err
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Samples an active-low multiplexed seven-segment bus, filters ghosting with a stable-run
// counter and publishes a full multi-digit hex value once every digit has been captured.
module sseg_scan_decoder #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 3
) (
  input logic                clk,
  input logic                rst,
  sseg_scan_decoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE + 1);
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [DIGITS-1:0] DigOne = DIGITS'(1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHeld
  } state_e;

  state_e              state_q, state_d;
  logic [DIGITS-1:0]   an_q;
  logic [7:0]          seg_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   sblank_q, sblank_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                frame_valid_q, frame_valid_d;
  logic                code_err_q, code_err_d;

  logic                changed;
  logic                in_valid;
  logic [DIGITS-1:0]   in_sel;
  logic                commit;
  logic                known;
  logic                is_blank;
  logic [3:0]          nibble;
  logic [IdxW-1:0]     idx;
  logic [DIGITS-1:0]   slot_bit;

  // Exactly one anode low: the inverted vector must be a non-zero power of two.
  assign in_sel   = ~bus.an;
  assign in_valid = (in_sel != '0) && ((in_sel & (in_sel - DigOne)) == '0);
  assign changed  = ({bus.an, bus.seg} != {an_q, seg_q});
  assign commit   = (state_q == StSettle) && (cnt_q == CntMax);

  always_comb begin
    known    = 1'b1;
    is_blank = 1'b0;
    nibble   = 4'h0;
    case (seg_q)
      8'h40:   nibble = 4'h0;
      8'h79:   nibble = 4'h1;
      8'h24:   nibble = 4'h2;
      8'h30:   nibble = 4'h3;
      8'h19:   nibble = 4'h4;
      8'h12:   nibble = 4'h5;
      8'h02:   nibble = 4'h6;
      8'h78:   nibble = 4'h7;
      8'h00:   nibble = 4'h8;
      8'h10:   nibble = 4'h9;
      8'h08:   nibble = 4'hA;
      8'h03:   nibble = 4'hB;
      8'h46:   nibble = 4'hC;
      8'h21:   nibble = 4'hD;
      8'h06:   nibble = 4'hE;
      8'h0E:   nibble = 4'hF;
      8'hFF:   is_blank = 1'b1;
      default: known = 1'b0;
    endcase
  end

  // Only consulted on commit, when the captured anode is known to be one-hot.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        idx = IdxW'(i);
      end
    end
  end

  assign slot_bit = DigOne << idx;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    seen_d        = seen_q;
    shadow_d      = shadow_q;
    sblank_d      = sblank_q;
    value_d       = value_q;
    blank_d       = blank_q;
    frame_valid_d = 1'b0;
    code_err_d    = 1'b0;

    if (changed) begin
      cnt_d = CntOne;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end

    if (commit) begin
      state_d = StHeld;
      if (known) begin
        shadow_d[{idx, 2'b00} +: 4] = nibble;
        sblank_d                    = is_blank ? (sblank_q | slot_bit) : (sblank_q & ~slot_bit);
        seen_d                      = seen_q | slot_bit;
        if (&seen_d) begin
          value_d       = shadow_d;
          blank_d       = sblank_d;
          frame_valid_d = 1'b1;
          seen_d        = '0;
        end
      end else begin
        code_err_d = 1'b1;
      end
    end

    // A new capture always restarts the run, even on the commit edge itself.
    if (changed) begin
      state_d = in_valid ? StSettle : StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      an_q          <= '1;
      seg_q         <= 8'hFF;
      cnt_q         <= '0;
      seen_q        <= '0;
      shadow_q      <= '0;
      sblank_q      <= '0;
      value_q       <= '0;
      blank_q       <= '1;
      frame_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      an_q          <= bus.an;
      seg_q         <= bus.seg;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      sblank_q      <= sblank_d;
      value_q       <= value_d;
      blank_q       <= blank_d;
      frame_valid_q <= frame_valid_d;
      code_err_q    <= code_err_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.blank_mask  = blank_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.code_err    = code_err_q;

endmodule
